system_led_out: RTL

- Avalon-MM slave output port for board LEDs: the write-side counterpart of the switch input port.
- The CPU writes an output data register, with atomic bit set/clear, plus a per-bit blink mask driven by a programmable prescaler.
- Sits on the system interconnect beside the switch input port; drives the LED pins directly.
- Register readback has 1-cycle latency, matching the input-port read timing.

---
 rtl/system_led_out_pkg.sv | 13 +
 rtl/system_led_blink_gen.sv | 30 +++
 rtl/system_led_out.sv | 79 +++++++
 3 files changed

// File: rtl/system_led_out_pkg.sv
// Shared register map constants for the LED output port.
package system_led_out_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_OUTSET = 3'd3;
  localparam logic [2:0] ADDR_OUTCLR = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int unsigned STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/system_led_blink_gen.sv
// Blink prescaler: phase toggles every period+1 cycles; a period write restarts it.
module system_led_blink_gen #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                period_wr,
  output logic                phase
);

  logic [PERIOD_W-1:0] counter;

  // A period write wins over a coincident wrap so the new period starts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
      phase   <= 1'b0;
    end else if (period_wr || period == '0) begin
      counter <= '0;
      phase   <= 1'b0;
    end else if (counter == period) begin
      counter <= '0;
      phase   <= ~phase;
    end else begin
      counter <= counter + 1'b1;
    end
  end

endmodule

// File: rtl/system_led_out.sv
// Avalon-MM LED output port: data register with set/clear, per-bit blink mask.
module system_led_out
  import system_led_out_pkg::*;
#(
  parameter int unsigned   WIDTH       = 8,
  parameter int unsigned   PERIOD_W    = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    mask;
  logic [PERIOD_W-1:0] period;
  logic                phase;
  logic                wr;
  logic                period_wr;
  logic [WIDTH-1:0]    wd;
  logic [31:0]         rd_next;
  logic                unused_wd;

  assign wr        = chipselect & ~write_n;
  assign period_wr = wr && (address == ADDR_PERIOD);
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data   <= RESET_VALUE;
      mask   <= '0;
      period <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data   <= wd;
        ADDR_MASK:   mask   <= wd;
        ADDR_PERIOD: period <= writedata[PERIOD_W-1:0];
        ADDR_OUTSET: data   <= data | wd;
        ADDR_OUTCLR: data   <= data & ~wd;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:   rd_next[WIDTH-1:0]    = data;
      ADDR_MASK:   rd_next[WIDTH-1:0]    = mask;
      ADDR_PERIOD: rd_next[PERIOD_W-1:0] = period;
      ADDR_STATUS: rd_next[STATUS_PHASE_BIT] = phase;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  system_led_blink_gen #(
    .PERIOD_W(PERIOD_W)
  ) u_blink (
    .clk       (clk),
    .reset_n   (reset_n),
    .period    (period),
    .period_wr (period_wr),
    .phase     (phase)
  );

  assign out_port = data ^ (mask & {WIDTH{phase}});

endmodule
